// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared core-wide definitions. The writeback arbiter pulls in the data
//   width, the writeback source indices and the queued result type from here.
//   No ports; package only.
package riscv_pkg;

    localparam int XLEN = 32;

    // Writeback source indices (arbiter input slots).
    localparam int WB_SRC_ALU    = 0;
    localparam int WB_SRC_LSU    = 1;
    localparam int WB_SRC_MULDIV = 2;

    // One queued writeback result.
    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo
//   Small synchronous FIFO of wb_req_t results. It uses wrap-around read and
//   write pointers plus an occupancy count. DEPTH must be a power of two
//   (>= 2), so the pointers wrap by natural overflow.
//
// Ports
//   clk, reset_n : clock, asynchronous active-low reset (empties the queue)
//   push, wdata  : enqueue wdata when push && !full
//   pop          : dequeue the head when pop && !empty
//   rdata        : current head entry (only meaningful when !empty)
//   full, empty  : occupancy flags, derived from registered state only
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  wb_req_t wdata,
    input  logic    pop,
    output wb_req_t rdata,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    wb_req_t       mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: reset empties the queue, so stale contents are
    // never read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Shares the regfile's single write port among NUM_SRC result producers
//   (0 = ALU, 1 = LSU, 2 = MULDIV). Each producer pushes (rd, data) through a
//   valid/ready handshake into its own wb_fifo. A round-robin arbiter pops one
//   head per cycle into a registered write port. Results addressed to x0
//   complete the handshake and are dropped.
//
//   Optional feature macro: WB_SCOREBOARD_EN. When it is defined, busy_mask
//   tracks destination registers that have an issued but not yet granted
//   write. When it is undefined, issue_* are ignored and busy_mask is 0.
//
// Ports
//   clk, reset_n          : clock, asynchronous active-low reset
//   src_valid/src_ready   : per-source handshake (ready = queue not full)
//   src_rd, src_data      : per-source result
//   rf_wr_en/rf_rd/rf_write_data : registered regfile write port
//   idle                  : all queues empty and no write this cycle
//   issue_valid, issue_rd : issuing instruction's destination (scoreboard)
//   busy_mask             : pending-write bit per architectural register
module wb_arbiter
    import riscv_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC-1:0][4:0]       src_rd,
    input  logic [NUM_SRC-1:0][XLEN-1:0]  src_data,
    output logic                          rf_wr_en,
    output logic [4:0]                    rf_rd,
    output logic [XLEN-1:0]               rf_write_data,
    output logic                          idle,
    input  logic                          issue_valid,
    input  logic [4:0]                    issue_rd,
    output logic [31:0]                   busy_mask
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] fifo_full;
    logic [NUM_SRC-1:0] fifo_empty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    wb_req_t            head [NUM_SRC];

    logic               grant;
    logic [PW-1:0]      win_idx;
    logic [PW:0]        cand;
    wb_req_t            win_req;

    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               rf_wr_en_q;
    logic [4:0]         rf_rd_q;
    logic [XLEN-1:0]    rf_data_q;

    // ------------------------------------------------------------------
    // Per-source queues
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        wb_req_t wdata;

        assign wdata.rd   = src_rd[g];
        assign wdata.data = src_data[g];

        // x0 results still see ready, but are never enqueued.
        assign push[g] = src_valid[g] && !fifo_full[g] && (src_rd[g] != 5'd0);
        assign pop[g]  = grant && (win_idx == PW'(g));

        wb_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (push[g]),
            .wdata   (wdata),
            .pop     (pop[g]),
            .rdata   (head[g]),
            .full    (fifo_full[g]),
            .empty   (fifo_empty[g])
        );
    end

    assign src_ready = ~fifo_full;

    // ------------------------------------------------------------------
    // Round-robin pick: scan from rr_ptr upward, wrapping modulo NUM_SRC.
    // cand is one bit wider so the wrap compare works for any NUM_SRC.
    // ------------------------------------------------------------------
    always_comb begin
        grant   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NUM_SRC)) begin
                cand = cand - (PW+1)'(NUM_SRC);
            end
            if (!grant && !fifo_empty[cand[PW-1:0]]) begin
                grant   = 1'b1;
                win_idx = cand[PW-1:0];
            end
        end
    end

    assign win_req = head[win_idx];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (win_idx == PW'(NUM_SRC - 1)) ? '0 : win_idx + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registered write port. Address and data hold when nothing is granted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q   <= '0;
            rf_wr_en_q <= 1'b0;
            rf_rd_q    <= '0;
            rf_data_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rf_wr_en_q <= grant;
            if (grant) begin
                rf_rd_q   <= win_req.rd;
                rf_data_q <= win_req.data;
            end
        end
    end

    assign rf_wr_en      = rf_wr_en_q;
    assign rf_rd         = rf_rd_q;
    assign rf_write_data = rf_data_q;
    assign idle          = (&fifo_empty) && !rf_wr_en_q;

    // ------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------
`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    // The set is applied after the clear: a same-edge issue to the register
    // being written belongs to a newer producer, so it must stay busy.
    always_comb begin
        busy_d = busy_q;
        if (grant) begin
            busy_d[win_req.rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_mask = busy_q;
`else
    logic unused_issue;

    assign unused_issue = ^{issue_valid, issue_rd};
    assign busy_mask    = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
    import riscv_pkg::*;

    localparam int NS = 3;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [NS-1:0]            src_valid;
    logic [NS-1:0]            src_ready;
    logic [NS-1:0][4:0]       src_rd;
    logic [NS-1:0][XLEN-1:0]  src_data;
    logic                     rf_wr_en;
    logic [4:0]               rf_rd;
    logic [XLEN-1:0]          rf_write_data;
    logic                     idle;
    logic                     issue_valid;
    logic [4:0]               issue_rd;
    logic [31:0]              busy_mask;

    int checks = 0;
    int errors = 0;

    wb_req_t exp_q [$];
    wb_req_t mon_e;

    wb_arbiter #(
        .NUM_SRC    (NS),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .src_rd        (src_rd),
        .src_data      (src_data),
        .rf_wr_en      (rf_wr_en),
        .rf_rd         (rf_rd),
        .rf_write_data (rf_write_data),
        .idle          (idle),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .busy_mask     (busy_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every regfile write is matched against the expected-write queue.
    always @(negedge clk) begin
        if (rf_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=rd%0d/%h required=no write at %0t",
                         rf_rd, rf_write_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_rd", 32'(rf_rd), 32'(mon_e.rd));
                check("wr_data", rf_write_data, mon_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        src_valid   = '0;
        src_rd      = '0;
        src_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
    endtask

    task automatic drive(input logic [1:0] s, input logic [4:0] rd, input logic [31:0] d);
        src_valid[s] = 1'b1;
        src_rd[s]    = rd;
        src_data[s]  = d;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        wb_req_t e;
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        clear_inputs();
        #2;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        check("rst_wr_en", 32'(rf_wr_en), 32'd0);
        check("rst_rd", 32'(rf_rd), 32'd0);
        check("rst_data", rf_write_data, 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_ready", 32'(src_ready), 32'h7);
        check("rst_busy", busy_mask, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();

        // ---- single ALU push, latency and idle ----
        do_reset();
        drive(2'd0, 5'd5, 32'hDEADBEEF);
        expect_wr(5'd5, 32'hDEADBEEF);
        tick();                                   // E: accepted
        clear_inputs();
        check("t1_wren_E", 32'(rf_wr_en), 32'd0);
        check("t1_idle_E", 32'(idle), 32'd0);
        tick();                                   // E+1: granted
        check("t1_wren_E1", 32'(rf_wr_en), 32'd1);
        check("t1_rd_E1", 32'(rf_rd), 32'd5);
        tick();
        check("t1_idle_E2", 32'(idle), 32'd1);
        check("t1_wren_E2", 32'(rf_wr_en), 32'd0);
        check("t1_rd_hold", 32'(rf_rd), 32'd5);
        check("t1_data_hold", rf_write_data, 32'hDEADBEEF);

        // ---- all three sources every cycle: grant order 0,1,2,0,1,2,0 ----
        do_reset();
        expect_wr(5'd1, 32'hA000_0001);
        expect_wr(5'd2, 32'hB000_0001);
        expect_wr(5'd3, 32'hC000_0001);
        expect_wr(5'd1, 32'hA000_0002);
        expect_wr(5'd2, 32'hB000_0002);
        expect_wr(5'd3, 32'hC000_0002);
        expect_wr(5'd1, 32'hA000_0003);
        for (int k = 1; k <= 3; k++) begin
            drive(2'd0, 5'd1, 32'hA000_0000 + 32'(k));
            drive(2'd1, 5'd2, 32'hB000_0000 + 32'(k));
            drive(2'd2, 5'd3, 32'hC000_0000 + 32'(k));
            tick();
            if (k == 2) begin
                check("t2_ready_e2", 32'(src_ready), 32'h1);
                check("t2_wren_e2", 32'(rf_wr_en), 32'd1);
            end
            if (k == 3) begin
                check("t2_ready_e3", 32'(src_ready), 32'h2);
            end
        end
        clear_inputs();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_wren_cont", 32'(rf_wr_en), 32'd1);
        end
        tick();
        check("t2_wren_end", 32'(rf_wr_en), 32'd0);
        check("t2_idle_end", 32'(idle), 32'd1);

        // ---- LSU backpressure under ALU/MULDIV traffic ----
        do_reset();
        expect_wr(5'd10, 32'h1000_0001);
        expect_wr(5'd11, 32'h2000_0001);
        expect_wr(5'd12, 32'h3000_0001);
        expect_wr(5'd10, 32'h1000_0002);
        expect_wr(5'd11, 32'h2000_0002);
        expect_wr(5'd12, 32'h3000_0002);
        expect_wr(5'd10, 32'h1000_0003);
        expect_wr(5'd11, 32'h2000_0003);
        drive(2'd0, 5'd10, 32'h1000_0001);
        drive(2'd1, 5'd11, 32'h2000_0001);
        drive(2'd2, 5'd12, 32'h3000_0001);
        tick();
        drive(2'd0, 5'd10, 32'h1000_0002);
        drive(2'd1, 5'd11, 32'h2000_0002);
        drive(2'd2, 5'd12, 32'h3000_0002);
        tick();
        check("t3_lsu_ready_full", 32'(src_ready[1]), 32'd0);
        check("t3_ready_e2", 32'(src_ready), 32'h1);
        drive(2'd0, 5'd10, 32'h1000_0003);
        drive(2'd1, 5'd11, 32'h2000_0003);   // refused, held one more cycle
        drive(2'd2, 5'd12, 32'h3000_0003);   // refused, withdrawn
        tick();
        check("t3_ready_e3", 32'(src_ready), 32'h2);
        clear_inputs();
        drive(2'd1, 5'd11, 32'h2000_0003);
        tick();
        check("t3_ready_e4", 32'(src_ready), 32'h4);
        clear_inputs();
        for (int k = 0; k < 6; k++) tick();
        check("t3_idle_end", 32'(idle), 32'd1);

        // ---- x0 result is accepted and discarded ----
        do_reset();
        drive(2'd2, 5'd0, 32'h0000_1234);
        check("t4_ready_x0", 32'(src_ready[2]), 32'd1);
        tick();
        clear_inputs();
        check("t4_ready_after", 32'(src_ready), 32'h7);
        for (int k = 0; k < 3; k++) begin
            check("t4_idle", 32'(idle), 32'd1);
            check("t4_wren", 32'(rf_wr_en), 32'd0);
            tick();
        end

        // ---- asynchronous reset mid-drain ----
        do_reset();
        expect_wr(5'd20, 32'h5555_0001);
        drive(2'd0, 5'd20, 32'h5555_0001);
        drive(2'd1, 5'd21, 32'h5555_0002);
        tick();
        clear_inputs();
        drive(2'd2, 5'd22, 32'h5555_0003);
        tick();
        clear_inputs();
        check("t5_wren_pre", 32'(rf_wr_en), 32'd1);
        check("t5_idle_pre", 32'(idle), 32'd0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_wren", 32'(rf_wr_en), 32'd0);
        check("t5_async_rd", 32'(rf_rd), 32'd0);
        check("t5_async_data", rf_write_data, 32'd0);
        check("t5_async_idle", 32'(idle), 32'd1);
        check("t5_async_ready", 32'(src_ready), 32'h7);
        check("t5_async_busy", busy_mask, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("t5_idle_after", 32'(idle), 32'd1);

        // ---- scoreboard ----
        do_reset();
`ifdef WB_SCOREBOARD_EN
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();                                   // E: set
        clear_inputs();
        check("t6_busy_E", 32'(busy_mask[7]), 32'd1);
        tick();
        check("t6_busy_E1", 32'(busy_mask[7]), 32'd1);
        drive(2'd0, 5'd7, 32'h0000_0077);
        expect_wr(5'd7, 32'h0000_0077);
        tick();                                   // push
        clear_inputs();
        check("t6_busy_push", 32'(busy_mask[7]), 32'd1);
        tick();                                   // grant: clear
        check("t6_busy_grant", 32'(busy_mask[7]), 32'd0);
        check("t6_wren_grant", 32'(rf_wr_en), 32'd1);
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        clear_inputs();
        tick();
        drive(2'd0, 5'd7, 32'h0000_0078);
        expect_wr(5'd7, 32'h0000_0078);
        tick();                                   // push
        clear_inputs();
        issue_valid = 1'b1;                       // re-issue on the grant edge
        issue_rd    = 5'd7;
        tick();
        clear_inputs();
        check("t6_busy_set_wins", busy_mask, 32'h0000_0080);
        check("t6_wren_reissue", 32'(rf_wr_en), 32'd1);
`else
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        clear_inputs();
        check("t6_busy_off", busy_mask, 32'd0);
        drive(2'd0, 5'd7, 32'h0000_0077);
        expect_wr(5'd7, 32'h0000_0077);
        tick();
        clear_inputs();
        tick();
        check("t6_wren_off", 32'(rf_wr_en), 32'd1);
        check("t6_busy_off2", busy_mask, 32'd0);
`endif
        tick();
        tick();
        check("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
